uart_tx: RTL and testbench

Serialising UART transmitter stage that sits directly downstream of tx_interface.
- tx_interface presents a result byte on din and pulses tx_start; this block shifts the byte out on the serial line.
- On completion it returns a one-cycle tx_done_tick to tx_interface.
- Bit timing comes from the shared baud-rate generator's s_tick (16x oversampling), so the stage contains no baud arithmetic of its own.

---
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Serialising UART transmitter: start bit, DBIT data bits LSB first, optional
// parity bit, then a stop period of SB_TICK oversampling ticks. Bit timing is
// taken entirely from the external 16x s_tick strobe.
//
// Handshake: tx_start is a request that is only looked at while the block is
// idle (busy = 0); the byte on din is captured on that same edge and din is
// free to change afterwards. A request while busy is dropped, not queued.
// tx_done_tick pulses for exactly one clk on the final stop tick; the block is
// idle (and able to accept tx_start) from the following clk onward.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       busy,
  output logic       tx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DBIT);
  localparam logic [5:0] SB_LAST   = 6'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  localparam logic       PAR_ODD   = 1'(PARITY == 2);
  localparam logic       HAS_PAR   = 1'(PARITY != 0);

  state_t     state_reg, state_next;
  logic [5:0] s_reg, s_next;
  logic [2:0] n_reg, n_next;
  logic [7:0] b_reg, b_next;
  logic       par_reg, par_next;
  logic       tx_reg, tx_next;

  // State and datapath registers; reset returns the line to idle-high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic: every bit slot lasts 16 s_ticks, the stop slot SB_TICK.
  always_comb begin
    state_next   = state_reg;
    s_next       = s_reg;
    n_next       = n_reg;
    b_next       = b_reg;
    par_next     = par_reg;
    tx_done_tick = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tx_start) begin
          b_next     = din;
          s_next     = '0;
          par_next   = (^(din & DATA_MASK)) ^ PAR_ODD;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_reg == 6'd15) begin
            s_next     = '0;
            n_next     = '0;
            state_next = ST_DATA;
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_reg == 6'd15) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
              state_next = HAS_PAR ? ST_PAR : ST_STOP;
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      ST_PAR: begin
        if (s_tick) begin
          if (s_reg == 6'd15) begin
            s_next     = '0;
            state_next = ST_STOP;
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_reg == SB_LAST) begin
            s_next       = '0;
            tx_done_tick = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line level is chosen from the state being entered so tx moves on the
  // same edge as the state register (start bit one clk after acceptance).
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = b_next[0];
      ST_PAR:   tx_next = par_next;
      default:  tx_next = 1'b1;
    endcase
  end

  assign busy = (state_reg != ST_IDLE);
  assign tx   = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (no parity, even, odd, and a 5-bit /
// 2-stop / odd variant) share one stimulus stream. A slot-level frame model
// predicts tx, busy and tx_done_tick every cycle; directed frames pin the
// model with hand-written bit patterns.
module tb_uart_tx;

  localparam int NDUT = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tx_start = 1'b0;
  logic            s_tick = 1'b0;
  logic [7:0]      din = 8'h00;
  logic [NDUT-1:0] tx_o, busy_o, done_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt[NDUT] = '{default: 0};
  int last_done_cyc0 = 0;
  int tick_mode = 0;
  int phase = 0;
  logic [0:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_dut0 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
    .tx_done_tick(done_o[0]), .busy(busy_o[0]), .tx(tx_o[0]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_dut1 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
    .tx_done_tick(done_o[1]), .busy(busy_o[1]), .tx(tx_o[1]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_dut2 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
    .tx_done_tick(done_o[2]), .busy(busy_o[2]), .tx(tx_o[2]));
  uart_tx #(.DBIT(5), .SB_TICK(32), .PARITY(2)) u_dut3 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
    .tx_done_tick(done_o[3]), .busy(busy_o[3]), .tx(tx_o[3]));

  // ---------------- reference model ----------------
  function automatic int dbit_of(input int k);
    return (k == 3) ? 5 : 8;
  endfunction
  function automatic int sb_of(input int k);
    return (k == 3) ? 32 : 16;
  endfunction
  function automatic int par_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 2);
  endfunction
  function automatic int nbits_of(input int k);
    return 2 + dbit_of(k) + ((par_of(k) != 0) ? 1 : 0);
  endfunction
  function automatic int dur_of(input int k, input int idx);
    return (idx == nbits_of(k) - 1) ? sb_of(k) : 16;
  endfunction
  // Whole frame as a list of line levels, slot 0 = start bit.
  function automatic logic [11:0] frame_of(input int k, input logic [7:0] d);
    logic [11:0] f;
    logic p;
    f = '1;
    f[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < dbit_of(k); i++) begin
      f[1 + i] = d[i];
      p = p ^ d[i];
    end
    if (par_of(k) != 0) f[1 + dbit_of(k)] = (par_of(k) == 1) ? p : ~p;
    return f;
  endfunction

  logic        m_active[NDUT];
  logic [11:0] m_bits[NDUT];
  int          m_idx[NDUT];
  int          m_cnt[NDUT];

  // Model advance: which slot of which frame each instance is in, and how
  // many ticks of that slot have elapsed.
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < NDUT; k++) begin
      if (reset) begin
        m_active[k] <= 1'b0;
        m_idx[k]    <= 0;
        m_cnt[k]    <= 0;
        m_bits[k]   <= '1;
      end else if (!m_active[k]) begin
        if (tx_start) begin
          m_active[k] <= 1'b1;
          m_idx[k]    <= 0;
          m_cnt[k]    <= 0;
          m_bits[k]   <= frame_of(k, din);
        end
      end else if (s_tick) begin
        if (m_cnt[k] == dur_of(k, m_idx[k]) - 1) begin
          m_cnt[k] <= 0;
          if (m_idx[k] == nbits_of(k) - 1) m_active[k] <= 1'b0;
          else m_idx[k] <= m_idx[k] + 1;
        end else begin
          m_cnt[k] <= m_cnt[k] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      logic e_tx, e_busy, e_done;
      e_tx   = m_active[k] ? m_bits[k][m_idx[k]] : 1'b1;
      e_busy = m_active[k];
      e_done = m_active[k] && s_tick && (m_idx[k] == nbits_of(k) - 1) &&
               (m_cnt[k] == dur_of(k, m_idx[k]) - 1);
      check($sformatf("tx[%0d]", k), 32'(tx_o[k]), 32'(e_tx));
      check($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(e_busy));
      check($sformatf("done[%0d]", k), 32'(done_o[k]), 32'(e_done));
      if (done_o[k]) done_cnt[k]++;
    end
    if (done_o[0]) last_done_cyc0 = cyc;
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    case (tick_mode)
      0: begin
        phase = (phase + 1) % 10;
        s_tick = (phase == 0);
      end
      1: s_tick = ($urandom_range(0, 2) == 0);
      default: s_tick = 1'b1;
    endcase
  endtask

  task automatic push_pattern(input logic [9:0] pat);
    for (int i = 0; i < 10; i++) exp_q.push_back(pat[i]);
  endtask

  // One frame with ticks every 10 clks; samples DUT0 mid-slot against exp_q.
  task automatic frame_directed(input logic [7:0] d, input bit repulse,
                                input int p1, input int p2);
    int start_cyc, d0, dt;
    bit busy_drop;
    din = d;
    tx_start = 1'b1;
    next_cycle();
    tx_start = 1'b0;
    start_cyc = cyc;
    d0 = done_cnt[0];
    busy_drop = 1'b0;
    for (int off = 0; off < 1800; off++) begin
      if (off > 0) next_cycle();
      if (repulse && off == 80 + 160 * 3) begin
        din = 8'hFF;
        tx_start = 1'b1;
      end
      if (repulse && off == 81 + 160 * 3) tx_start = 1'b0;
      if (off < 1580 && busy_o[0] !== 1'b1) busy_drop = 1'b1;
      if (off % 160 == 80 && exp_q.size() > 0) check("slot_bit", 32'(tx_o[0]), 32'(exp_q.pop_front()));
      if (off == 80 + 160 * 9 && p1 >= 0) begin
        check("parity_even", 32'(tx_o[1]), p1);
        check("parity_odd", 32'(tx_o[2]), p2);
      end
    end
    dt = last_done_cyc0 - start_cyc;
    check("busy_held", 32'(busy_drop), 0);
    check("done_count", done_cnt[0] - d0, 1);
    check("done_time", 32'(dt >= 1590 && dt <= 1610), 1);
    check("idle_after", 32'(busy_o), 0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4000 && busy_o != '0; i++) next_cycle();
    check(name, 32'(busy_o), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, d1;
    tick_mode = 0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    check("rst_tx", 32'(tx_o), 32'hF);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    tick_mode = 1;
    for (int i = 0; i < 50; i++) next_cycle();
    check("idle_tx", 32'(tx_o), 32'hF);
    check("idle_busy", 32'(busy_o), 0);

    tick_mode = 0;
    // D5: start, 1,0,1,0,1,0,1,1, stop
    push_pattern(10'b11_1010_1010);
    frame_directed(8'hD5, 1'b0, -1, -1);
    // 07: start, 1,1,1,0,0,0,0,0, stop; parity even 1, odd 0
    push_pattern(10'b10_0000_1110);
    frame_directed(8'h07, 1'b0, 1, 0);
    // 3C with FF re-pulse mid-DATA: start, 0,0,1,1,1,1,0,0, stop
    push_pattern(10'b10_0111_1000);
    frame_directed(8'h3C, 1'b1, -1, -1);

    // tx_start held high across frames.
    din = 8'($urandom);
    tx_start = 1'b1;
    d0 = done_cnt[0];
    for (int i = 0; i < 2500 && done_cnt[0] == d0; i++) next_cycle();
    check("hold_done_seen", 32'(done_cnt[0] != d0), 1);
    check("gap_tx", 32'(tx_o[0]), 1);
    check("gap_busy", 32'(busy_o[0]), 0);
    next_cycle();
    check("restart_tx", 32'(tx_o[0]), 0);
    check("restart_busy", 32'(busy_o[0]), 1);
    d1 = done_cnt[0];
    for (int i = 0; i < 1590; i++) next_cycle();
    check("no_early_done", done_cnt[0] - d1, 0);
    tx_start = 1'b0;
    drain("drain_hold");

    // Asynchronous reset during DATA bit 3.
    din = 8'($urandom);
    tx_start = 1'b1;
    next_cycle();
    tx_start = 1'b0;
    for (int off = 1; off <= 80 + 160 * 4; off++) next_cycle();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx_o), 32'hF);
    check("async_rst_busy", 32'(busy_o), 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    // A1: start, 1,0,0,0,0,1,0,1, stop
    push_pattern(10'b11_0100_0010);
    frame_directed(8'hA1, 1'b0, -1, -1);

    // Randomized traffic: random ticks, then continuous ticks.
    for (int i = 0; i < 13000; i++) begin
      if (i == 10000) tick_mode = 2;
      if (i < 10000) tick_mode = 1;
      next_cycle();
      din = 8'($urandom);
      tx_start = ($urandom_range(0, 149) == 0) || (i % 2500 < 300 && i > 2500);
      if (i == 7000) begin
        #2;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
      end
    end
    tx_start = 1'b0;
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
